traffic_phase_ctrl: RTL
=======================

Name: traffic_phase_ctrl

Overview:
Phase sequencer that sits directly downstream of the seconds counter and consumes its one-per-second terminal pulse. It steps a two-approach intersection through the phases NS green, NS yellow, all-red, EW green, EW yellow, all-red, with a remaining-seconds countdown for display. It also supports pedestrian-request green shortening and a night flashing-yellow mode. Its outputs drive the lamp drivers and the countdown display decoder.

Parameters:
pGREEN_NS, 30, NS green duration in seconds (1..99)
pGREEN_EW, 25, EW green duration in seconds (1..99)
pYELLOW, 3, yellow duration in seconds for both approaches (1..99)
pALL_RED, 2, all-red clearance duration in seconds (1..99)
pGREEN_MIN, 5, green floor after a pedestrian request (1..min(greens)-1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global run enable; 0 freezes state, remain and flash
sec_tick  in  1  single-cycle pulse, one per second, from the seconds counter terminal output
ped_req  in  1  pedestrian button, level or pulse, sampled every clk
night  in  1  night-mode request level
ns_light  out  3  {R,Y,G} one-hot lamp drive for the NS approach; 000 = dark
ew_light  out  3  {R,Y,G} one-hot lamp drive for the EW approach
remain  out  7  seconds left in the current phase (1..99); 0 in FLASH
phase_done  out  1  one-clock pulse in the cycle after any state change
ped_ack  out  1  one-clock pulse when a pending pedestrian request is serviced

Behaviour:
- One clock domain, asynchronous active-low reset; all outputs registered.
- Reset values:
  - state = AR_EW (clearance after EW), remain = pALL_RED
  - ns_light = ew_light = 100; phase_done = 0; ped_ack = 0
  - ped_pending = 0; flash_q = 1
- States and lamps (NS/EW):
  - NS_G: 001/100
  - NS_Y: 010/100
  - AR_NS: 100/100
  - EW_G: 100/001
  - EW_Y: 100/010
  - AR_EW: 100/100
  - FLASH: both 010 when flash_q = 1, both 000 when flash_q = 0
- Qualified tick: qt = en & sec_tick. Nothing but ped_pending updates while en = 0.
- Countdown:
  - On entry to a phase, remain loads that phase's duration.
  - On each qt, if remain > 1, decrement.
  - If remain == 1, transition to the next state and load its duration in the same clock.
  - Each phase therefore lasts exactly its duration in qt events.
- Sequence: NS_G→NS_Y→AR_NS→EW_G→EW_Y→AR_EW→NS_G.
- Night mode:
  - Entry: night is sampled only on the terminating qt of AR_NS or AR_EW. If night = 1, go to FLASH instead; remain = 0, flash_q = 1.
  - In FLASH, flash_q toggles on every qt.
  - Exit: on a qt with night = 0, go to AR_EW with remain = pALL_RED. This forces full clearance before NS green.
- Pedestrian handling:
  - ped_req = 1 sets ped_pending, which holds until serviced.
  - Pending is serviced only when state ∈ {NS_G, EW_G} and en = 1, on the first such clock.
  - If remain > pGREEN_MIN, remain loads pGREEN_MIN.
  - Otherwise remain is unchanged.
  - In both cases ped_pending clears and ped_ack pulses one clock later.
  - If servicing coincides with qt, servicing wins: remain = pGREEN_MIN and that tick's decrement is dropped. Exception: when remain == 1, the qt transition wins and the pending request stays set for the next green.
  - ped_req arriving in the same clock as service re-arms ped_pending.
- FLASH ignores ped_pending; it remains latched.
- phase_done is a registered delay of "state changed this clock". Entry into FLASH and exit from FLASH both count.
- Mid-operation reset returns immediately to the reset values; no partial phase is resumed.
- Width rules: remain is 7-bit unsigned, never wraps, never 0 outside FLASH. Elaboration error if any duration is outside 1..99 or pGREEN_MIN ≥ min(pGREEN_NS, pGREEN_EW).

Decomposition:
- Shared package traffic_pkg:
  - state enum
  - lamp codes RED = 3'b100, YEL = 3'b010, GRN = 3'b001, OFF = 3'b000
  - CNT_W = 7, MAX_SEC = 99
- One natural sub-module, phase_down_counter, with ports clk, rst_n, load, load_val, dec; outputs val and is_one. The FSM, pedestrian latch and flash toggle stay in the top.

Test Plan:
- Reset release, en = 1, sec_tick every 10 clk:
  - remain 2→1, then NS_G with remain = 30 and ns_light = 001 after the 2nd tick; phase_done pulses once.
  - Full cycle = 30+3+2+25+3+2 = 65 ticks back to NS_G.
- ped_req pulse at NS_G remain = 20 → next clock remain = 5, ped_ack pulse; NS_Y after 5 more ticks.
- ped_req at NS_G remain = 3 → remain unchanged, ped_ack pulses. ped_req during NS_Y → held pending, serviced on EW_G entry: remain 25→5.
- en = 0 for 50 ticks mid-EW_G (remain = 12) → remain stays 12, lamps frozen; resumes 11 on the first qt after en = 1.
- night = 1 during EW_G → FLASH only at the end of AR_EW; lamps toggle 010/000 each tick, remain = 0. night = 0 → AR_EW with remain = 2, then NS_G.
- Assert rst_n low mid-NS_Y, coincident with sec_tick and ped_req → all outputs at reset values, ped_pending = 0.

Source files
------------

// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared types and constants for the intersection phase sequencer.
// Phase encoding, lamp codes and the phase successor / lamp decode helpers.
package traffic_pkg;

    localparam int CNT_W   = 7;
    localparam int MAX_SEC = 99;

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR_NS = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR_EW = 3'd5,
        FLASH = 3'd6
    } phase_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    // Normal day sequence; FLASH always leaves through EW clearance.
    function automatic phase_t next_phase(input phase_t s);
        case (s)
            NS_G:    return NS_Y;
            NS_Y:    return AR_NS;
            AR_NS:   return EW_G;
            EW_G:    return EW_Y;
            EW_Y:    return AR_EW;
            default: return NS_G;
        endcase
    endfunction

    // Returns {ns_light, ew_light}.
    function automatic logic [5:0] lamps(input phase_t s, input logic flash);
        case (s)
            NS_G:    return {GRN, RED};
            NS_Y:    return {YEL, RED};
            EW_G:    return {RED, GRN};
            EW_Y:    return {RED, YEL};
            FLASH:   return flash ? {YEL, YEL} : {OFF, OFF};
            default: return {RED, RED};
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Control inputs and lamp/countdown outputs of the phase sequencer.
// master drives the requests, slave is the sequencer itself.
interface traffic_phase_ctrl_if;
    import traffic_pkg::*;

    logic             en;
    logic             sec_tick;
    logic             ped_req;
    logic             night;
    logic [2:0]       ns_light;
    logic [2:0]       ew_light;
    logic [CNT_W-1:0] remain;
    logic             phase_done;
    logic             ped_ack;

    modport master (
        output en, sec_tick, ped_req, night,
        input  ns_light, ew_light, remain, phase_done, ped_ack
    );

    modport slave (
        input  en, sec_tick, ped_req, night,
        output ns_light, ew_light, remain, phase_done, ped_ack
    );

endinterface

// File: rtl/phase_down_counter.sv
// Seconds-left counter: load has priority, dec stops at 1 so it never wraps.
// Latency: val updates one clock after load/dec; no backpressure.
module phase_down_counter
    import traffic_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = 7'd2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] val,
    output logic             is_one
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val <= RST_VAL;
        end else if (load) begin
            val <= load_val;
        end else if (dec && (val > CNT_W'(1))) begin
            val <= val - CNT_W'(1);
        end
    end

    assign is_one = (val == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-approach phase sequencer with ped green shortening and night flash.
// Latency: one clock from qualified tick/request to registered outputs; no backpressure.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int pGREEN_NS  = 30,
    parameter int pGREEN_EW  = 25,
    parameter int pYELLOW    = 3,
    parameter int pALL_RED   = 2,
    parameter int pGREEN_MIN = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    traffic_phase_ctrl_if.slave   bus
);

    localparam int GREEN_LO = (pGREEN_NS < pGREEN_EW) ? pGREEN_NS : pGREEN_EW;

    if (pGREEN_NS < 1 || pGREEN_NS > MAX_SEC || pGREEN_EW < 1 || pGREEN_EW > MAX_SEC ||
        pYELLOW < 1 || pYELLOW > MAX_SEC || pALL_RED < 1 || pALL_RED > MAX_SEC ||
        pGREEN_MIN < 1 || pGREEN_MIN >= GREEN_LO) begin : g_bad_param
        $error("traffic_phase_ctrl: phase duration parameter out of range");
    end

    localparam logic [CNT_W-1:0] GMIN = CNT_W'(pGREEN_MIN);

    function automatic logic [CNT_W-1:0] dur(input phase_t s);
        case (s)
            NS_G:         return CNT_W'(pGREEN_NS);
            EW_G:         return CNT_W'(pGREEN_EW);
            NS_Y, EW_Y:   return CNT_W'(pYELLOW);
            AR_NS, AR_EW: return CNT_W'(pALL_RED);
            default:      return '0;
        endcase
    endfunction

    phase_t           state, state_n;
    logic             flash_q, flash_n;
    logic             ped_pending;
    logic             qt, svc;
    logic             cnt_load, cnt_dec, cnt_one;
    logic [CNT_W-1:0] cnt_ld_val, cnt_val;

    phase_down_counter #(.RST_VAL(CNT_W'(pALL_RED))) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .val      (cnt_val),
        .is_one   (cnt_one)
    );

    always_comb begin
        state_n    = state;
        flash_n    = flash_q;
        cnt_load   = 1'b0;
        cnt_ld_val = cnt_val;
        cnt_dec    = 1'b0;
        qt         = bus.en & bus.sec_tick;
        // A terminating tick in green beats the request, which then waits for the next green.
        svc        = bus.en & ped_pending & ((state == NS_G) || (state == EW_G)) & ~(qt & cnt_one);
        if (svc) begin
            if (cnt_val > GMIN) begin
                cnt_load   = 1'b1;
                cnt_ld_val = GMIN;
            end
        end else if (qt) begin
            if (state == FLASH) begin
                if (!bus.night) begin
                    state_n    = AR_EW;
                    cnt_load   = 1'b1;
                    cnt_ld_val = dur(AR_EW);
                end else begin
                    flash_n = ~flash_q;
                end
            end else if (cnt_one) begin
                cnt_load = 1'b1;
                if (((state == AR_NS) || (state == AR_EW)) && bus.night) begin
                    state_n    = FLASH;
                    flash_n    = 1'b1;
                    cnt_ld_val = '0;
                end else begin
                    state_n    = next_phase(state);
                    cnt_ld_val = dur(next_phase(state));
                end
            end else begin
                cnt_dec = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= AR_EW;
            flash_q        <= 1'b1;
            ped_pending    <= 1'b0;
            bus.ped_ack    <= 1'b0;
            bus.phase_done <= 1'b0;
            bus.ns_light   <= RED;
            bus.ew_light   <= RED;
        end else begin
            state                        <= state_n;
            flash_q                      <= flash_n;
            ped_pending                  <= bus.ped_req | (ped_pending & ~svc);
            bus.ped_ack                  <= svc;
            bus.phase_done               <= (state_n != state);
            {bus.ns_light, bus.ew_light} <= lamps(state_n, flash_n);
        end
    end

    assign bus.remain = cnt_val;

endmodule
